lcd_instruction_transmitter: RTL and testbench

- Consumes the 12-bit instruction clock count and owns that counter's enable.
- Sends one 8-bit LCD instruction or data byte over the 4-bit LCD bus: upper nibble, 1 us gap, lower nibble, then a 40 us settle time.
- Sits between the init/command sequencer (upstream, start/done handshake) and the LCD pins. Timing is at 50 MHz.

---
 rtl/lcd_instruction_transmitter_pkg.sv | 37 +++
 rtl/lcd_instruction_transmitter.sv | 150 +++++++++++++++
 tb/tb_lcd_instruction_transmitter.sv | 370 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_instruction_transmitter_pkg.sv
// Shared definitions for the LCD instruction transmitter: the transfer
// states and the clk_cnt landmarks of one 4-bit-bus byte transfer.
package lcd_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    UPPER = 3'd1,
    GAP   = 3'd2,
    LOWER = 3'd3,
    WAIT  = 3'd4
  } lcdState_e;

  // Count landmarks at 50 MHz (one count = 20 ns)
  localparam logic [11:0] E_START    = 12'd2;
  localparam logic [11:0] E_CYCLES   = 12'd12;
  localparam logic [11:0] LOWER_BASE = 12'd65;
  localparam logic [11:0] CNT_LAST   = 12'd2080;

  localparam logic [11:0] UPPER_END  = 12'd14;
  localparam logic [11:0] GAP_END    = 12'd64;
  localparam logic [11:0] LOWER_END  = 12'd79;

  // Enable-strobe windows, one per nibble
  localparam logic [11:0] E_UPPER_FIRST = E_START;
  localparam logic [11:0] E_UPPER_LAST  = E_START + E_CYCLES - 12'd1;
  localparam logic [11:0] E_LOWER_FIRST = LOWER_BASE + E_START;
  localparam logic [11:0] E_LOWER_LAST  = LOWER_BASE + E_START + E_CYCLES - 12'd1;

  // True when cnt lies inside the lcd_e window of the selected nibble
  function automatic logic nibble_phase(input logic [11:0] cnt, input logic lowerHalf);
    if (lowerHalf) begin
      return (cnt >= E_LOWER_FIRST) && (cnt <= E_LOWER_LAST);
    end
    return (cnt >= E_UPPER_FIRST) && (cnt <= E_UPPER_LAST);
  endfunction

endpackage

// File: rtl/lcd_instruction_transmitter.sv
// Sends one byte to an HD44780-style LCD over the 4-bit bus: upper nibble,
// 1 us gap, lower nibble, then a 40 us settle. All timing comes from the
// external instruction clock counter, whose enable this block owns.
module lcd_instruction_transmitter
  import lcd_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        rs_in,
  input  logic [7:0]  data_in,
  input  logic [11:0] clk_cnt,
  output logic        cnt_enable,
  output logic        lcd_e,
  output logic        lcd_rs,
  output logic        lcd_rw,
  output logic [3:0]  lcd_db,
  output logic        busy,
  output logic        done
);

  lcdState_e  r_state;
  lcdState_e  w_nextState;
  logic       r_resync;
  logic       w_nextResync;
  logic [7:0] r_byte;
  logic       r_rs;
  logic       w_latch;

  logic       r_lcdE;
  logic       r_lcdRs;
  logic [3:0] r_lcdDb;
  logic       r_done;
  logic       w_eNext;
  logic       w_rsNext;
  logic [3:0] w_dbNext;
  logic       w_doneNext;

  logic       w_cntIsZero;

  assign w_cntIsZero = (clk_cnt == 12'd0);

  // A corrupted counter found at start is run round to zero before any
  // bus activity; the enable drops on the zero count so the transfer
  // begins exactly on count 0.
  assign cnt_enable = (r_state != IDLE) || (r_resync && !w_cntIsZero);
  assign busy       = (r_state != IDLE) || r_resync;

  assign lcd_e  = r_lcdE;
  assign lcd_rs = r_lcdRs;
  assign lcd_db = r_lcdDb;
  assign lcd_rw = 1'b0;
  assign done   = r_done;

  // Next-state and next-output decode from the current state and count
  always_comb begin
    w_nextState  = r_state;
    w_nextResync = r_resync;
    w_latch      = 1'b0;
    w_eNext      = 1'b0;
    w_rsNext     = 1'b0;
    w_dbNext     = r_lcdDb;
    w_doneNext   = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_resync) begin
          if (w_cntIsZero) begin
            w_nextState  = UPPER;
            w_nextResync = 1'b0;
          end
        end else if (start) begin
          w_latch = 1'b1;
          if (w_cntIsZero) begin
            w_nextState = UPPER;
          end else begin
            w_nextResync = 1'b1;
          end
        end
      end
      UPPER: begin
        w_eNext  = nibble_phase(clk_cnt, 1'b0);
        w_rsNext = r_rs;
        w_dbNext = r_byte[7:4];
        if (clk_cnt == UPPER_END) begin
          w_nextState = GAP;
        end
      end
      GAP: begin
        w_rsNext = r_rs;
        w_dbNext = r_byte[7:4];
        if (clk_cnt == GAP_END) begin
          w_nextState = LOWER;
        end
      end
      LOWER: begin
        w_eNext  = nibble_phase(clk_cnt, 1'b1);
        w_rsNext = r_rs;
        w_dbNext = r_byte[3:0];
        if (clk_cnt == LOWER_END) begin
          w_nextState = WAIT;
        end
      end
      WAIT: begin
        w_rsNext = r_rs;
        w_dbNext = r_byte[3:0];
        if (clk_cnt == CNT_LAST) begin
          w_nextState = IDLE;
          w_doneNext  = 1'b1;
        end
      end
      default: begin
        w_nextState  = IDLE;
        w_nextResync = 1'b0;
      end
    endcase
  end

  // State register, desync flag and the byte/rs captured on an accepted start
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_resync <= 1'b0;
      r_byte   <= 8'h00;
      r_rs     <= 1'b0;
    end else begin
      r_state  <= w_nextState;
      r_resync <= w_nextResync;
      if (w_latch) begin
        r_byte <= data_in;
        r_rs   <= rs_in;
      end
    end
  end

  // Registered LCD pins: one cycle behind the count, so lcd_e is glitch-free
  always_ff @(posedge clk) begin
    if (reset) begin
      r_lcdE  <= 1'b0;
      r_lcdRs <= 1'b0;
      r_lcdDb <= 4'h0;
      r_done  <= 1'b0;
    end else begin
      r_lcdE  <= w_eNext;
      r_lcdRs <= w_rsNext;
      r_lcdDb <= w_dbNext;
      r_done  <= w_doneNext;
    end
  end

endmodule

// File: tb/tb_lcd_instruction_transmitter.sv
// Self-checking bench for lcd_instruction_transmitter. A small counter model
// stands in for the instruction clock counter; expected pin activity comes
// from a per-transfer timeline model indexed by clock edges since start.
module tb_lcd_instruction_transmitter;

  typedef struct packed {
    logic        busy;
    logic        done;
    logic        e;
    logic        rs;
    logic        rw;
    logic [3:0]  db;
    logic        en;
    logic [11:0] cnt;
  } obs_t;

  typedef struct {
    int eCount;
    int riseCount;
    int riseA;
    int riseB;
    int doneCount;
    int doneK;
    int busyCnt;
  } stats_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        rs_in;
  logic [7:0]  data_in;
  logic [11:0] clk_cnt;
  logic        cnt_enable;
  logic        lcd_e;
  logic        lcd_rs;
  logic        lcd_rw;
  logic [3:0]  lcd_db;
  logic        busy;
  logic        done;

  logic        loadReq;
  logic [11:0] loadVal;

  int errors = 0;
  int checks = 0;
  int firstRise = -1;

  lcd_instruction_transmitter dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .rs_in      (rs_in),
    .data_in    (data_in),
    .clk_cnt    (clk_cnt),
    .cnt_enable (cnt_enable),
    .lcd_e      (lcd_e),
    .lcd_rs     (lcd_rs),
    .lcd_rw     (lcd_rw),
    .lcd_db     (lcd_db),
    .busy       (busy),
    .done       (done)
  );

  // 50 MHz clock
  always #10 clk = ~clk;

  // Instruction clock counter: counts 0..2080 while enabled, then wraps
  always @(posedge clk) begin
    if (reset) clk_cnt <= 12'd0;
    else if (loadReq) clk_cnt <= loadVal;
    else if (cnt_enable) clk_cnt <= (clk_cnt == 12'd2080) ? 12'd0 : clk_cnt + 12'd1;
  end

  function automatic obs_t sample();
    obs_t o;
    o.busy = busy;
    o.done = done;
    o.e    = lcd_e;
    o.rs   = lcd_rs;
    o.rw   = lcd_rw;
    o.db   = lcd_db;
    o.en   = cnt_enable;
    o.cnt  = clk_cnt;
    return o;
  endfunction

  // Expected pins k edges after the edge that accepted start. The pins show
  // the decode of the count one edge earlier: count c is on the bus after
  // edge c+1. Upper nibble covers counts 0..64, lower 65..2080, lcd_e is
  // high for counts 2..13 and 67..78, the counter runs for counts 0..2080.
  function automatic obs_t modelAt(int k, logic [7:0] b, logic rs);
    obs_t m;
    int   c;
    c      = k - 1;
    m.busy = (k <= 2080);
    m.en   = (k <= 2080);
    m.done = (k == 2081);
    m.e    = (c >= 2 && c <= 13) || (c >= 67 && c <= 78);
    m.rs   = (k >= 1) ? rs : 1'b0;
    m.rw   = 1'b0;
    m.db   = (c <= 64) ? b[7:4] : b[3:0];
    m.cnt  = (k <= 2080) ? 12'(k) : 12'd0;
    return m;
  endfunction

  // Drives one transfer from posedge+1 and compares every cycle to the
  // model; optionally pulses a second start when the count is ignoreAt.
  task automatic runTransfer(input logic [7:0] b, input logic rs, input int ignoreAt,
                             input string tag, output stats_t st);
    obs_t o, m, mask;
    logic prevE;
    start   = 1'b1;
    rs_in   = rs;
    data_in = b;
    prevE   = lcd_e;
    st.eCount = 0; st.riseCount = 0; st.riseA = -1; st.riseB = -1;
    st.doneCount = 0; st.doneK = -1; st.busyCnt = 0;
    for (int k = 0; k <= 2081; k++) begin
      @(posedge clk);
      #1;
      if (k == 0) begin
        start   = 1'b0;
        data_in = ~b;
        rs_in   = ~rs;
      end
      if (ignoreAt >= 0 && k == ignoreAt + 1) start = 1'b0;
      o    = sample();
      m    = modelAt(k, b, rs);
      mask = '1;
      if (k == 0) mask.db = 4'h0;
      checks++;
      if ((o & mask) !== (m & mask)) begin
        errors++;
        $display("[TB] FAIL %s k=%0d got busy=%b done=%b e=%b rs=%b rw=%b db=%h en=%b cnt=%0d exp busy=%b done=%b e=%b rs=%b rw=%b db=%h en=%b cnt=%0d",
                 tag, k, o.busy, o.done, o.e, o.rs, o.rw, o.db, o.en, o.cnt,
                 m.busy, m.done, m.e, m.rs, m.rw, m.db, m.en, m.cnt);
      end
      if (o.e) st.eCount++;
      if (o.e && !prevE) begin
        st.riseCount++;
        if (st.riseA < 0) st.riseA = k;
        else if (st.riseB < 0) st.riseB = k;
      end
      if (o.done) begin
        st.doneCount++;
        st.doneK = k;
      end
      if (o.busy) st.busyCnt++;
      prevE = o.e;
      if (k == ignoreAt) begin
        start   = 1'b1;
        data_in = 8'($urandom);
        rs_in   = ~rs;
      end
    end
  endtask

  task automatic test_reset();
    obs_t o;
    reset = 1'b1; start = 1'b0; rs_in = 1'b0; data_in = 8'h00; loadReq = 1'b0; loadVal = 12'd0;
    repeat (3) @(posedge clk);
    #1;
    o = sample();
    checks++;
    if (o !== obs_t'(0)) begin
      errors++;
      $display("[TB] FAIL reset_values got=%h exp=%h", o, obs_t'(0));
    end
    reset = 1'b0;
    @(posedge clk);
    #1;
    o = sample();
    checks++;
    if (o !== obs_t'(0)) begin
      errors++;
      $display("[TB] FAIL idle_after_reset got=%h exp=%h", o, obs_t'(0));
    end
  endtask

  task automatic test_instruction();
    stats_t st;
    runTransfer(8'h28, 1'b0, -1, "instr_28", st);
    firstRise = st.riseA;
    checks++;
    if (st.eCount !== 24) begin
      errors++; $display("[TB] FAIL instr_e_width got=%0d exp=24", st.eCount);
    end
    checks++;
    if (st.riseB - st.riseA !== 65) begin
      errors++; $display("[TB] FAIL instr_rise_spacing got=%0d exp=65", st.riseB - st.riseA);
    end
    checks++;
    if (st.doneK + 1 !== 2082) begin
      errors++; $display("[TB] FAIL instr_start_to_done got=%0d exp=2082", st.doneK + 1);
    end
  endtask

  task automatic test_data();
    stats_t st;
    runTransfer(8'h41, 1'b1, -1, "data_41", st);
    checks++;
    if (st.busyCnt !== 2081) begin
      errors++; $display("[TB] FAIL data_busy_len got=%0d exp=2081", st.busyCnt);
    end
  endtask

  task automatic test_ignored_start();
    stats_t st;
    runTransfer(8'($urandom), 1'($urandom), 500, "ignored_start", st);
    checks++;
    if (st.riseCount !== 2 || st.doneCount !== 1) begin
      errors++;
      $display("[TB] FAIL ignored_start_counts got rises=%0d dones=%0d exp rises=2 dones=1",
               st.riseCount, st.doneCount);
    end
  endtask

  task automatic test_back_to_back();
    stats_t st;
    runTransfer(8'h0C, 1'b0, -1, "b2b_0C", st);
    checks++;
    if (st.riseA !== firstRise) begin
      errors++; $display("[TB] FAIL b2b_first_rise got=%0d exp=%0d", st.riseA, firstRise);
    end
    runTransfer(8'($urandom), 1'($urandom), -1, "b2b_rand", st);
    checks++;
    if (st.riseA !== firstRise) begin
      errors++; $display("[TB] FAIL b2b_rand_first_rise got=%0d exp=%0d", st.riseA, firstRise);
    end
  endtask

  task automatic test_random();
    stats_t st;
    obs_t   o;
    int     gap;
    for (int t = 0; t < 3; t++) begin
      gap = int'($urandom_range(0, 5));
      for (int g = 0; g < gap; g++) begin
        @(posedge clk);
        #1;
        o = sample();
        checks++;
        if (o.busy !== 1'b0 || o.e !== 1'b0 || o.done !== 1'b0 || o.en !== 1'b0 || o.rs !== 1'b0) begin
          errors++;
          $display("[TB] FAIL random_idle got busy=%b e=%b done=%b en=%b rs=%b exp all 0",
                   o.busy, o.e, o.done, o.en, o.rs);
        end
      end
      runTransfer(8'($urandom), 1'($urandom), -1, "random", st);
    end
  endtask

  task automatic test_reset_mid();
    stats_t st;
    obs_t   o;
    start = 1'b1; rs_in = 1'b1; data_in = 8'($urandom);
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    checks++;
    if (clk_cnt !== 12'd8 || lcd_e !== 1'b1) begin
      errors++; $display("[TB] FAIL reset_mid_setup got cnt=%0d e=%b exp cnt=8 e=1", clk_cnt, lcd_e);
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    o = sample();
    checks++;
    if (o !== obs_t'(0)) begin
      errors++; $display("[TB] FAIL reset_mid_clear got=%h exp=%h", o, obs_t'(0));
    end
    runTransfer(8'($urandom), 1'($urandom), -1, "after_reset", st);
  endtask

  task automatic test_start_reset();
    obs_t o;
    start = 1'b1; reset = 1'b1; rs_in = 1'b1; data_in = 8'hA5;
    @(posedge clk);
    #1;
    start = 1'b0; reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      o = sample();
      checks++;
      if (o !== obs_t'(0)) begin
        errors++; $display("[TB] FAIL start_reset_idle cyc=%0d got=%h exp=%h", i, o, obs_t'(0));
      end
    end
  endtask

  task automatic test_desync();
    logic [7:0] b;
    logic       prevE, seenZero, finished;
    int         eViol, eCount, rises, dones;
    logic [3:0] nibA, nibB;
    b = 8'($urandom);
    loadReq = 1'b1; loadVal = 12'd2000;
    @(posedge clk);
    #1;
    loadReq = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (clk_cnt !== 12'd2000 || busy !== 1'b0 || lcd_e !== 1'b0) begin
      errors++;
      $display("[TB] FAIL desync_setup got cnt=%0d busy=%b e=%b exp cnt=2000 busy=0 e=0", clk_cnt, busy, lcd_e);
    end
    start = 1'b1; rs_in = 1'b0; data_in = b;
    prevE = 1'b0; seenZero = 1'b0; finished = 1'b0;
    eViol = 0; eCount = 0; rises = 0; dones = 0; nibA = 4'h0; nibB = 4'h0;
    for (int i = 0; i < 3000 && !finished; i++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      if (!seenZero && lcd_e) eViol++;
      if (clk_cnt == 12'd0) seenZero = 1'b1;
      if (lcd_e) eCount++;
      if (lcd_e && !prevE) begin
        rises++;
        if (rises == 1) nibA = lcd_db;
        if (rises == 2) nibB = lcd_db;
      end
      prevE = lcd_e;
      if (done) begin
        dones++;
        finished = 1'b1;
      end
    end
    checks++;
    if (!finished) begin
      errors++; $display("[TB] FAIL desync_timeout got done=0 exp done within 3000 cycles");
    end
    checks++;
    if (eViol !== 0) begin
      errors++; $display("[TB] FAIL desync_quiet got e_before_zero=%0d exp=0", eViol);
    end
    checks++;
    if (eCount !== 24 || rises !== 2 || dones !== 1) begin
      errors++;
      $display("[TB] FAIL desync_transfer got e=%0d rises=%0d dones=%0d exp e=24 rises=2 dones=1",
               eCount, rises, dones);
    end
    checks++;
    if (nibA !== b[7:4] || nibB !== b[3:0]) begin
      errors++;
      $display("[TB] FAIL desync_nibbles got %h/%h exp %h/%h", nibA, nibB, b[7:4], b[3:0]);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; rs_in = 1'b0; data_in = 8'h00;
    loadReq = 1'b0; loadVal = 12'd0;
    test_reset();
    test_instruction();
    test_data();
    test_ignored_start();
    test_back_to_back();
    test_random();
    test_reset_mid();
    test_start_reset();
    test_desync();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
